// File: rtl/muldiv_sched_if.sv
// EX-side handshake between the decoder/pipeline and the multiply/divide sequencer.
// master = EX stage driving requests; slave = muldiv_sched.
interface muldiv_sched_if;
  logic        start;
  logic        mul_or_div;
  logic        is_sign;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mul_or_div, is_sign, opa, opb, flush,
    input  stall, result_valid, hi, lo
  );

  modport slave (
    input  start, mul_or_div, is_sign, opa, opb, flush,
    output stall, result_valid, hi, lo
  );
endinterface

// File: rtl/muldiv_sched.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer feeding HI/LO; freezes IF..EX while busy, one-cycle result pulse.
// Optional MD_DIV_EARLY_EXIT_EN: divides with |opb|==0 or |opa|<|opb| finish straight from the acceptance cycle.
module muldiv_sched #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_BITS   = 32
) (
  input logic           clk,
  input logic           rst,
  muldiv_sched_if.slave md
);

  localparam int CW = $clog2(DIV_BITS + 1);
`ifdef MD_DIV_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q;
  logic          rv_q;
  logic [31:0]   a_q, b_q, rem_q, quo_q, hi_q, lo_q;

  logic        idle, sign_s, step_ok, early_d;
  logic [31:0] a_s, b_s, abs_a, abs_b, rem_in, quo_in, rem_d, quo_d;
  logic [31:0] q_raw, r_raw, div_hi_d, div_lo_d;
  logic [32:0] partial;
  logic [63:0] prod_d;

  // In IDLE the datapath looks at the live operands so the acceptance edge already does useful work.
  always_comb begin
    idle     = (state_q == IDLE);
    a_s      = idle ? md.opa : a_q;
    b_s      = idle ? md.opb : b_q;
    sign_s   = idle ? md.is_sign : sign_q;
    abs_a    = (sign_s & a_s[31]) ? (~a_s + 32'd1) : a_s;
    abs_b    = (sign_s & b_s[31]) ? (~b_s + 32'd1) : b_s;

    rem_in   = idle ? 32'd0 : rem_q;
    quo_in   = idle ? abs_a : quo_q;
    partial  = {rem_in, quo_in[31]};
    step_ok  = (partial >= {1'b0, abs_b});
    rem_d    = step_ok ? 32'(partial - {1'b0, abs_b}) : partial[31:0];
    quo_d    = {quo_in[30:0], step_ok};

    early_d  = EarlyExit & idle & ((abs_b == 32'd0) | (abs_a < abs_b));
    q_raw    = early_d ? {32{abs_b == 32'd0}} : quo_d;
    r_raw    = early_d ? abs_a : rem_d;
    div_lo_d = (sign_s & (a_s[31] ^ b_s[31])) ? (~q_raw + 32'd1) : q_raw;
    div_hi_d = (sign_s & a_s[31]) ? (~r_raw + 32'd1) : r_raw;

    // Low 64 bits of the product of extended operands are correct for both signednesses.
    prod_d   = {{32{sign_s & a_s[31]}}, a_s} * {{32{sign_s & b_s[31]}}, b_s};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      rv_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      rv_q <= 1'b0;
      if (md.flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (md.start) begin
              a_q    <= md.opa;
              b_q    <= md.opb;
              sign_q <= md.is_sign;
              cnt_q  <= CW'(1);
              if (md.mul_or_div) begin
                if (MUL_CYCLES == 1) begin
                  state_q      <= DONE;
                  rv_q         <= 1'b1;
                  {hi_q, lo_q} <= prod_d;
                end else begin
                  state_q <= MUL;
                end
              end else if (early_d) begin
                state_q <= DONE;
                rv_q    <= 1'b1;
                hi_q    <= div_hi_d;
                lo_q    <= div_lo_d;
              end else begin
                state_q <= DIV;
                rem_q   <= rem_d;
                quo_q   <= quo_d;
              end
            end
          end
          MUL: begin
            if (cnt_q == CW'(MUL_CYCLES - 1)) begin
              state_q      <= DONE;
              rv_q         <= 1'b1;
              {hi_q, lo_q} <= prod_d;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DIV: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == CW'(DIV_BITS - 1)) begin
              state_q <= DONE;
              rv_q    <= 1'b1;
              hi_q    <= div_hi_d;
              lo_q    <= div_lo_d;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign md.stall = ~rst & ((idle & md.start & ~md.flush) | (state_q == MUL) | (state_q == DIV));
  assign md.result_valid = rv_q;
  assign md.hi = hi_q;
  assign md.lo = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed vectors plus randomized ops against an arithmetic model.
module tb_muldiv_sched;
  localparam int MC = 2;
`ifdef MD_DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    bit          m;
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err = 0;
  logic [31:0] last_hi, last_lo;

  always #5 clk = ~clk;

  muldiv_sched_if md();
  muldiv_sched #(.MUL_CYCLES(MC), .DIV_BITS(32)) dut (.clk(clk), .rst(rst), .md(md));

  // Reference: plain 64-bit arithmetic; signed division truncates toward zero.
  function automatic logic [63:0] ref_md(input bit m, input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      if (s) return 64'(sa * sb);
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
    end
    if (s) begin
      if (sb == 0) begin
        q = (sa < 0) ? 1 : -1;
        r = sa;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else if (b == 32'd0) begin
      q = 64'hFFFF_FFFF;
      r = longint'(a);
    end else begin
      q = longint'(a / b);
      r = longint'(a % b);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Cycles from the start cycle (counted as 1) to the result_valid cycle.
  function automatic int exp_lat(input bit m, input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa, ab;
    aa = (s && a[31]) ? -a : a;
    ab = (s && b[31]) ? -b : b;
    if (m) return MC + 1;
    return (EARLY && (ab == 32'd0 || aa < ab)) ? 2 : 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Holds start like a stalled EX stage, including the DONE cycle, and scrambles operands after acceptance.
  task automatic do_op(input bit m, input bit s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stalls, output bit got,
                       output logic [31:0] h, output logic [31:0] l);
    lat = 1; stalls = 0; got = 1'b0; h = '0; l = '0;
    @(negedge clk);
    md.start = 1'b1; md.mul_or_div = m; md.is_sign = s; md.opa = a; md.opb = b; md.flush = 1'b0;
    while (!got && lat < 100) begin
      #1;
      if (md.stall) stalls++;
      if (md.result_valid) begin
        got = 1'b1; h = md.hi; l = md.lo;
      end else begin
        @(negedge clk);
        lat++;
        md.opa = $urandom; md.opb = $urandom;
      end
    end
    @(negedge clk);
    md.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    md.start = 1'b1; md.mul_or_div = 1'b1; md.is_sign = 1'b0;
    md.opa = 32'd5; md.opb = 32'd7; md.flush = 1'b0;
    #3;
    n_checks++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b want=0", md.stall); end
    n_checks++; if (md.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv got=%b want=0", md.result_valid); end
    n_checks++; if ({md.hi, md.lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got=%h want=0", {md.hi, md.lo}); end
    @(negedge clk);
    md.start = 1'b0;
    rst = 1'b0;
    last_hi = 32'd0; last_lo = 32'd0;
  endtask

  task automatic run_table(input string name, input vec_t tbl[]);
    int lat, stalls, el;
    bit got;
    logic [31:0] h, l;
    foreach (tbl[i]) begin
      do_op(tbl[i].m, tbl[i].s, tbl[i].a, tbl[i].b, lat, stalls, got, h, l);
      el = exp_lat(tbl[i].m, tbl[i].s, tbl[i].a, tbl[i].b);
      n_checks++; if (!got) begin n_err++; $display("FAIL %s[%0d]_timeout no result_valid within 100 cycles", name, i); end
      n_checks++; if ({h, l} !== {tbl[i].eh, tbl[i].el})
        begin n_err++; $display("FAIL %s[%0d]_hilo got=%h_%h want=%h_%h", name, i, h, l, tbl[i].eh, tbl[i].el); end
      n_checks++; if (lat !== el) begin n_err++; $display("FAIL %s[%0d]_latency got=%0d want=%0d", name, i, lat, el); end
      n_checks++; if (stalls !== el - 1) begin n_err++; $display("FAIL %s[%0d]_stall_cycles got=%0d want=%0d", name, i, stalls, el - 1); end
      last_hi = tbl[i].eh; last_lo = tbl[i].el;
    end
  endtask

  task automatic test_mul;
    vec_t tbl[];
    tbl = '{
      '{1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA},
      '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
      '{1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
      '{1'b1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001}
    };
    run_table("mul", tbl);
  endtask

  task automatic test_div;
    vec_t tbl[];
    tbl = '{
      '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC},
      '{1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF},
      '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001},
      '{1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
      '{1'b0, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000},
      '{1'b0, 1'b1, 32'hFFFF_FFFB, 32'h0000_0007, 32'hFFFF_FFFB, 32'h0000_0000}
    };
    run_table("div", tbl);
  endtask

  // start still held in DONE must not launch a second operation.
  task automatic test_done_start;
    repeat (3) begin
      #1;
      n_checks++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL done_start_stall got=%b want=0", md.stall); end
      n_checks++; if (md.result_valid !== 1'b0) begin n_err++; $display("FAIL done_start_rv got=%b want=0", md.result_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush;
    int lat, stalls;
    bit got, seen;
    logic [31:0] h, l;
    @(negedge clk);
    md.start = 1'b1; md.mul_or_div = 1'b0; md.is_sign = 1'b0;
    md.opa = 32'h7FFF_0000; md.opb = 32'd3; md.flush = 1'b0;
    repeat (11) @(negedge clk);
    md.start = 1'b0; md.flush = 1'b1;
    @(negedge clk);
    md.flush = 1'b0;
    #1;
    n_checks++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got=%b want=0", md.stall); end
    n_checks++; if (md.result_valid !== 1'b0) begin n_err++; $display("FAIL flush_rv got=%b want=0", md.result_valid); end
    n_checks++; if ({md.hi, md.lo} !== {last_hi, last_lo})
      begin n_err++; $display("FAIL flush_hold_hilo got=%h_%h want=%h_%h", md.hi, md.lo, last_hi, last_lo); end
    do_op(1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, lat, stalls, got, h, l);
    n_checks++; if (!got || {h, l} !== 64'hFFFF_FFFF_FFFF_FFFA)
      begin n_err++; $display("FAIL flush_next_mult got=%h_%h valid=%b want=ffffffff_fffffffa", h, l, got); end
    n_checks++; if (lat !== MC + 1) begin n_err++; $display("FAIL flush_next_mult_latency got=%0d want=%0d", lat, MC + 1); end
    last_hi = 32'hFFFF_FFFF; last_lo = 32'hFFFF_FFFA;
    seen = 1'b0;
    repeat (40) begin
      #1; if (md.result_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_late_pulse got=%b want=0", seen); end
    md.start = 1'b1; md.flush = 1'b1; md.mul_or_div = 1'b1;
    #1;
    n_checks++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL flush_start_stall got=%b want=0", md.stall); end
    @(negedge clk);
    md.start = 1'b0; md.flush = 1'b0;
    #1;
    n_checks++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL flush_start_accepted got=%b want=0", md.stall); end
  endtask

  task automatic test_random;
    int lat, stalls, el;
    bit got, m, s;
    logic [31:0] a, b, h, l;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      a = pick(); b = pick();
      exp = ref_md(m, s, a, b);
      el = exp_lat(m, s, a, b);
      do_op(m, s, a, b, lat, stalls, got, h, l);
      n_checks++; if (!got || {h, l} !== exp)
        begin n_err++; $display("FAIL rand[%0d] m=%b s=%b a=%h b=%h got=%h_%h valid=%b want=%h", i, m, s, a, b, h, l, got, exp); end
      n_checks++; if (lat !== el) begin n_err++; $display("FAIL rand[%0d]_latency got=%0d want=%0d", i, lat, el); end
      last_hi = exp[63:32]; last_lo = exp[31:0];
    end
  endtask

  task automatic test_async_reset;
    int lat, stalls;
    bit got;
    logic [31:0] h, l;
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls, got, h, l);
    @(negedge clk);
    md.start = 1'b1; md.mul_or_div = 1'b0; md.is_sign = 1'b1;
    md.opa = 32'h1234_5678; md.opb = 32'd9; md.flush = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL arst_stall got=%b want=0", md.stall); end
    n_checks++; if (md.result_valid !== 1'b0) begin n_err++; $display("FAIL arst_rv got=%b want=0", md.result_valid); end
    n_checks++; if ({md.hi, md.lo} !== 64'd0) begin n_err++; $display("FAIL arst_hilo got=%h want=0", {md.hi, md.lo}); end
    @(negedge clk);
    md.start = 1'b0; rst = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      n_checks++; if (md.stall !== 1'b0 || md.result_valid !== 1'b0)
        begin n_err++; $display("FAIL arst_idle stall=%b rv=%b want 0/0", md.stall, md.result_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_done_start();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
